bit_plane_accumulator: RTL and testbench
========================================

# bit_plane_accumulator

Downstream stage of the 8-lane bit-plane adder tree in the systolic-array datapath. Takes one 16-bit tree sum per bit plane, LSB plane first, and shift-accumulates PLANES consecutive sums into one full-precision dot-product result. Results leave through a valid/ready output register. Input-side backpressure is applied only when a completed result cannot be retired.

## Interface
- IN_W, 16, width of the adder-tree sum.
- PLANES, 8, bit planes per result (≥2); plane index p carries weight 2^p.
- ACC_W, IN_W+PLANES, accumulator and result width.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_sum  input  IN_W  tree sum for the current plane, treated as unsigned.
- in_valid  input  1  in_sum is valid.
- in_ready  output  1  block accepts in_sum this cycle.
- out_data  output  ACC_W  completed result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- plane_idx  output  $clog2(PLANES)  index of the next plane to be accepted.

## Operation
- Accept: in_valid && in_ready. Each accept consumes one plane.
- plane_idx counts 0..PLANES-1 and wraps to 0 after the last plane.
- Term for plane p: in_sum zero-extended to ACC_W, then << p.
- Accumulator acc:
  - p==0: acc <= term, discarding any previous value.
  - Otherwise: acc <= acc + term, modulo 2^ACC_W.
- Last plane (p==PLANES-1):
  - out_data <= acc + term.
  - out_valid <= 1.
  - plane_idx <= 0.
- Output register:
  - Holds out_data stable while out_valid && !out_ready.
  - Cleared when out_valid && out_ready, unless a new last plane is accepted in the same cycle, in which case it reloads and out_valid stays 1.
- in_ready = !(out_valid && !out_ready && plane_idx==PLANES-1).
  - Non-last planes are always accepted, including during output backpressure.
  - Only the last plane stalls.
- States, derived from out_valid and plane_idx:
  - IDLE: idx 0, no pending output.
  - ACCUM: 0 < idx ≤ PLANES-1.
  - FULL: out_valid pending.
  - ACCUM and FULL may coexist.
- Gaps (in_valid low) at any plane are allowed; state is held.
- Unsigned worst case: (2^IN_W−1)(2^PLANES−1) < 2^ACC_W, so the result never overflows.

## Timing
- Reset values:
  - out_valid=0, out_data=0, acc=0, plane_idx=0.
  - in_ready=1 in the first cycle after reset.
- rst during a partial vector discards the partial sum and any pending output; the next accepted plane is plane 0.
- Latency: out_valid rises the cycle after the last plane is accepted.
- Throughput: one plane per cycle, back-to-back vectors with no bubble while out_ready=1.
- Last-plane accept with an old result being retired in the same cycle: the old result is taken, then the new one is loaded on that edge. No loss, no duplicate.
- in_ready is combinational from out_valid, out_ready and plane_idx. There is no path from in_valid.

## Configuration
- SIGNED_MSB_PLANE_EN defined:
  - Plane PLANES-1 carries weight −2^(PLANES-1), so its term is subtracted: out_data <= acc − (in_sum << (PLANES-1)).
  - out_data is two's-complement, modulo 2^ACC_W.
  - This supports signed activations.
- Not defined: all planes are added and out_data is unsigned.

## Test plan
1. Unsigned build, PLANES=8, in_sum=1 for all 8 planes, out_ready=1 → out_data=0x0000FF one cycle after plane 7; out_valid high for exactly one cycle.
2. Signed build, same stimulus → out_data=0xFFFFFF (−1). Plane 0 = 0x0003, others 0 → 0x000003.
3. Unsigned build, all planes 0xFFFF → 0xFEFF01. Then plane 0 = 0xFFFF, others 0 → 0x00FFFF. Confirms no carry-over from the previous vector.
4. Backpressure: hold out_ready=0 after the first result.
   - Planes 0–6 of the second vector are accepted.
   - in_ready drops at plane 7; out_data is held stable.
   - Raise out_ready → first result taken and plane 7 accepted in the same cycle → second result valid on the next cycle.
5. Gaps: toggle in_valid randomly across planes → result equals the gap-free reference. plane_idx advances only on accepts.
6. Assert rst after plane 4 with a result pending → out_valid=0 and plane_idx=0 the next cycle. A fresh 8-plane vector of 2s gives 0x0001FE (unsigned).

Source files
------------

// File: rtl/bit_plane_accumulator.sv
// bit_plane_accumulator: shift-accumulates PLANES bit-plane tree sums into one result; SIGNED_MSB_PLANE_EN makes the MSB plane negative
module bit_plane_accumulator #(
    parameter int IN_W   = 16,
    parameter int PLANES = 8,
    parameter int ACC_W  = IN_W + PLANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           in_sum,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(PLANES)-1:0] plane_idx
);
    localparam int IDX_W = $clog2(PLANES);
    logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d, term, sum;
    logic [IDX_W-1:0] plane_idx_q, plane_idx_d;
    logic             out_valid_q, out_valid_d, last, accept;
    assign last      = plane_idx_q == IDX_W'(PLANES - 1);
    // only the last plane can stall: it is the one that would overwrite a pending result
    assign in_ready  = !(out_valid_q && !out_ready && last);
    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign plane_idx = plane_idx_q;
    always_comb begin
        term        = ACC_W'(in_sum) << plane_idx_q;
`ifdef SIGNED_MSB_PLANE_EN
        sum         = last ? acc_q - term : acc_q + term;
`else
        sum         = acc_q + term;
`endif
        acc_d       = accept ? (plane_idx_q == '0 ? term : sum) : acc_q;
        plane_idx_d = accept ? (last ? '0 : plane_idx_q + IDX_W'(1)) : plane_idx_q;
        out_data_d  = (accept && last) ? sum : out_data_q;
        out_valid_d = (accept && last) ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            plane_idx_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            plane_idx_q <= plane_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_bit_plane_accumulator.sv
// tb_bit_plane_accumulator: randomized self-checking bench against an arithmetic dot-product model
module tb_bit_plane_accumulator;
    localparam int IN_W   = 16;
    localparam int PLANES = 8;
    localparam int ACC_W  = 24;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  in_sum = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       plane_idx;
    int               checks = 0;
    int               errors = 0;
    int               stalls = 0;
    logic [IN_W-1:0]  vec [PLANES];
    logic [ACC_W-1:0] exp_a, exp_b;

    bit_plane_accumulator dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .plane_idx(plane_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] ref_result();
        longint r = 0;
        for (int p = 0; p < PLANES; p++) begin
`ifdef SIGNED_MSB_PLANE_EN
            if (p == PLANES - 1) r -= longint'(vec[p]) * (longint'(1) << p);
            else r += longint'(vec[p]) * (longint'(1) << p);
`else
            r += longint'(vec[p]) * (longint'(1) << p);
`endif
        end
        return r[ACC_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_plane(input logic [IN_W-1:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_sum = s;
        while (!in_ready && n < 50) begin
            tick();
            n++;
            stalls++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int first, input int last_p);
        for (int p = first; p <= last_p; p++) send_plane(vec[p]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        if (plane_idx !== 3'd0) begin errors++; $display("FAIL reset_plane_idx got %0d want 0", plane_idx); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_ones();
        out_ready = 1'b1;
        for (int p = 0; p < PLANES; p++) vec[p] = 16'd1;
        exp_a = ref_result();
        send_vec(0, PLANES - 1);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid got %0b want 1", out_valid); end
        if (out_data !== exp_a) begin errors++; $display("FAIL ones_data got %h want %h", out_data, exp_a); end
        if (plane_idx !== 3'd0) begin errors++; $display("FAIL ones_idx_wrap got %0d want 0", plane_idx); end
        tick();
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_one_cycle got %0b want 0", out_valid); end
        for (int p = 0; p < PLANES; p++) vec[p] = (p == 0) ? 16'd3 : 16'd0;
        exp_a = ref_result();
        send_vec(0, PLANES - 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_a) begin
            errors++;
            $display("FAIL three_data valid=%0b got %h want %h", out_valid, out_data, exp_a);
        end
    endtask

    task automatic test_max();
        for (int p = 0; p < PLANES; p++) vec[p] = 16'hFFFF;
        exp_a = ref_result();
        send_vec(0, PLANES - 1);
        checks++;
        if (out_data !== exp_a) begin errors++; $display("FAIL max_data got %h want %h", out_data, exp_a); end
        for (int p = 0; p < PLANES; p++) vec[p] = (p == 0) ? 16'hFFFF : 16'd0;
        exp_a = ref_result();
        send_vec(0, PLANES - 1);
        checks++;
        if (out_data !== exp_a || exp_a !== 24'h00FFFF) begin
            errors++;
            $display("FAIL no_carry_over got %h want 00ffff", out_data);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        stalls = 0;
        for (int v = 0; v < 4; v++) begin
            for (int p = 0; p < PLANES; p++) vec[p] = IN_W'($urandom_range(0, 65535));
            exp_a = ref_result();
            send_vec(0, PLANES - 1);
            in_valid = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a) begin
                errors++;
                $display("FAIL b2b_data vec=%0d valid=%0b got %h want %h", v, out_valid, out_data, exp_a);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int p = 0; p < PLANES; p++) vec[p] = IN_W'($urandom_range(0, 65535));
        exp_a = ref_result();
        send_vec(0, PLANES - 1);
        for (int p = 0; p < PLANES; p++) vec[p] = IN_W'($urandom_range(0, 65535));
        exp_b = ref_result();
        stalls = 0;
        send_vec(0, PLANES - 2);
        checks += 2;
        if (stalls !== 0) begin errors++; $display("FAIL bp_early_stall got %0d want 0", stalls); end
        if (plane_idx !== 3'd7) begin errors++; $display("FAIL bp_idx got %0d want 7", plane_idx); end
        in_valid = 1'b1;
        in_sum = vec[PLANES-1];
        for (int c = 0; c < 3; c++) begin
            #1;
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0b want 1", out_valid); end
            if (out_data !== exp_a) begin errors++; $display("FAIL bp_hold_data got %h want %h", out_data, exp_a); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %0b want 1", out_valid); end
        if (out_data !== exp_b) begin errors++; $display("FAIL bp_second_data got %h want %h", out_data, exp_b); end
        if (plane_idx !== 3'd0) begin errors++; $display("FAIL bp_second_idx got %0d want 0", plane_idx); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_gaps();
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int p = 0; p < PLANES; p++) vec[p] = IN_W'($urandom_range(0, 65535));
            exp_a = ref_result();
            for (int p = 0; p < PLANES; p++) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_sum = IN_W'($urandom_range(0, 65535));
                    tick();
                end
                checks++;
                if (plane_idx !== 3'(p)) begin errors++; $display("FAIL gap_idx got %0d want %0d", plane_idx, p); end
                send_plane(vec[p]);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_a) begin
                errors++;
                $display("FAIL gap_data valid=%0b got %h want %h", out_valid, out_data, exp_a);
            end
        end
        tick();
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        for (int p = 0; p < PLANES; p++) vec[p] = IN_W'($urandom_range(0, 65535));
        send_vec(0, PLANES - 1);
        send_vec(0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", out_valid); end
        if (plane_idx !== 3'd0) begin errors++; $display("FAIL rst_mid_idx got %0d want 0", plane_idx); end
        out_ready = 1'b1;
        for (int p = 0; p < PLANES; p++) vec[p] = 16'd2;
        exp_a = ref_result();
        send_vec(0, PLANES - 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_a) begin
            errors++;
            $display("FAIL rst_mid_fresh valid=%0b got %h want %h", out_valid, out_data, exp_a);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_gaps();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
